// File: rtl/write_port_arbiter.sv
// Round-robin packet arbiter feeding the write-path channel selecter; holds one port for a whole packet.
// First beat one cycle after a request is seen; ds_ready low stalls the beat with owner, count and state held.
module write_port_arbiter #(
  parameter int num_of_ports = 16,
  parameter int len_width    = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [num_of_ports-1:0]           req,
  input  logic [num_of_ports*len_width-1:0] req_len,
  input  logic                              ds_ready,
  output logic [3:0]                        select,
  output logic                              enable,
  output logic [num_of_ports-1:0]           grant,
  output logic                              last,
  output logic                              busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state, state_nxt;
  logic [3:0]           rr_ptr, rr_ptr_nxt;
  logic [3:0]           select_nxt;
  logic [len_width-1:0] cnt, cnt_nxt;
  logic [3:0]           winner;
  logic                 req_any;
  logic [len_width-1:0] winner_len;

  // Scan upward from rr_ptr; the 4-bit add wraps 15 -> 0.
  always_comb begin
    logic [3:0] idx;
    winner  = '0;
    req_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < num_of_ports; i++) begin
      idx = rr_ptr + 4'(i);
      if (!req_any && req[idx]) begin
        winner  = idx;
        req_any = 1'b1;
      end
    end
  end

  assign winner_len = req_len[int'(winner)*len_width +: len_width];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      select <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      cnt    <= cnt_nxt;
      select <= select_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    select_nxt = select;
    busy       = (state == XFER);
    enable     = (state == XFER) && ds_ready;
    last       = enable && (cnt == '0);
    grant      = '0;
    if (enable) grant[select] = 1'b1;

    case (state)
      IDLE: begin
        if (req_any) begin
          select_nxt = winner;
          cnt_nxt    = winner_len;
          state_nxt  = XFER;
        end
      end
      XFER: begin
        // Just-served port drops to lowest priority for the next scan.
        if (enable) begin
          if (cnt == '0) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = select + 4'd1;
          end else begin
            cnt_nxt = cnt - len_width'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
